// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
//   XLEN          - PC / address width
//   INST_W        - instruction word width
//   fetch_state_t - fetch FSM states
//   fetch_entry_t - one fetch buffer entry {pc, instr}
//   NOP           - canonical RISC-V nop (addi x0, x0, 0)
package fetch_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned INST_W = 32;

    typedef enum logic [1:0] {
        RUN,
        HALT,
        FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] instr;
    } fetch_entry_t;

    localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of fetched {pc, instr} pairs.
//   clk, reset_n - clock, async active-low reset
//   flush        - drop all contents (wins over push/pop)
//   push, entry  - write entry at tail
//   pop          - retire head
//   head_valid   - at least one entry held
//   head         - oldest entry
//   count        - occupancy 0..2
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t entry,
    input  logic         pop,
    output logic         head_valid,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            // At count 2 a push only arrives together with a pop, so the
            // slot being overwritten is the one leaving this cycle.
            if (push) begin
                mem_q[wr_ptr_q] <= entry;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_valid = (count_q != 2'd0);
    assign head       = mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, fetches from a combinational
// instruction memory into a 2-entry buffer and hands instructions to decode
// over valid/ready. Handles execute redirects and stops past the image end.
//   clk, reset_n         - clock, async active-low reset
//   inst_address         - byte address to imem (current PC)
//   instruction          - imem word for inst_address (same cycle)
//   redirect_valid/target- PC change request from execute
//   out_valid/ready      - decode handshake
//   out_instruction/pc   - buffer head (0 when not valid)
//   halted               - PC ran past the image; fetching stopped
//   fault                - sticky misaligned redirect
module instruction_fetch_unit #(
    parameter int unsigned     XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     IMEM_BYTES = 152
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic [XLEN-1:0] inst_address,
    input  logic [31:0]     instruction,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instruction,
    output logic [XLEN-1:0] out_pc,
    output logic            halted,
    output logic            fault
);

    import fetch_pkg::*;

    localparam logic [XLEN-1:0] LAST_PC = XLEN'(IMEM_BYTES - 4);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            push, pop, flush;
    logic            head_valid;
    fetch_entry_t    head, push_entry;
    logic [1:0]      count;

    // Redirects are dead once faulted; the buffer is already empty then.
    assign flush = redirect_valid && (state_q != FAULT);
    assign pop   = head_valid && out_ready && !flush;

    assign push_entry = '{pc: pc_q, instr: instruction};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        unique case (state_q)
            RUN, HALT: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                    if (redirect_target[1:0] != 2'b00) begin
                        state_d = FAULT;
                    end else if (redirect_target > LAST_PC) begin
                        state_d = HALT;
                    end else begin
                        state_d = RUN;
                    end
                end else if (state_q == RUN) begin
                    if (pc_q > LAST_PC) begin
                        state_d = HALT;
                    end else if (count != 2'd2 || pop) begin
                        push = 1'b1;
                        pc_d = pc_q + XLEN'(4);
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .push       (push),
        .entry      (push_entry),
        .pop        (pop),
        .head_valid (head_valid),
        .head       (head),
        .count      (count)
    );

    assign inst_address    = pc_q;
    assign out_valid       = head_valid;
    assign out_instruction = head_valid ? head.instr : '0;
    assign out_pc          = head_valid ? head.pc : '0;
    assign halted          = (state_q == HALT);
    assign fault           = (state_q == FAULT);

endmodule
